multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle RV32I control FSM that drives the ALU's operation code and operand selects and consumes its flags (zero, signed_less_than) to resolve branches. It sits between the instruction register and the datapath muxes and register strobes. It also sequences the memory request/ready handshake for fetch, load and store.

Parameters:
ILLEGAL_HALT, 1, 1: illegal opcode enters HALT until reset; 0: flag and skip to FETCH

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
instr  input  32  current IR contents
zero  input  1  ALU zero flag
signed_less_than  input  1  ALU signed compare flag
mem_ready  input  1  memory accepted/completed current request
alu_operation  output  4  ALU op code
alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1, 11 zero
alu_src_b  output  2  00 rs2, 01 imm, 10 const 4
result_src  output  2  00 alu_out register, 01 mem data, 10 alu_c direct
adr_src  output  1  0 PC, 1 alu_out
mem_req  output  1  memory request
mem_write  output  1  store strobe
ir_write  output  1  IR/oldPC load
pc_write  output  1  PC load from result
reg_write  output  1  register-file write
retire  output  1  one-cycle pulse on final state of each instruction
illegal  output  1  sticky illegal-instruction flag

Behaviour:
- Clock and reset are fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=FETCH; illegal=0. All strobes are 0 in the reset cycle. A reset in any state, including a held memory wait, returns to FETCH next edge.
- Outputs are decoded combinationally from state and instr. pc_write in BRANCH also depends on the flags. Unlisted outputs are 0. alu_operation defaults to 0000.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SRL 0110, SRA 0111, SLL 1000, SLTU 1001.
- FETCH: mem_req=1, adr_src=0, a=PC, b=4, ADD, result_src=10. ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: a=oldPC, b=imm, ADD (branch/JAL/AUIPC target into alu_out). Next state by opcode:
  - 0000011, 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> EXEC_LUI
  - 0010111 -> ALU_WB
  - else -> ILLEGAL handling
- EXEC_R / EXEC_I: a=rs1, b=rs2 (R) or imm (I). Then ALU_WB.
  - Op mapping by funct3: 000 ADD (SUB only if R and instr[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by instr[30], 110 OR, 111 AND.
- EXEC_LUI: a=zero, b=imm, ADD. Then ALU_WB.
- ALU_WB: result_src=00, reg_write=1, retire=1. Then FETCH.
- MEM_ADR: a=rs1, b=imm, ADD. Load -> MEM_READ, store -> MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, retire=1. Then FETCH.
- MEM_WRITE: mem_req=mem_write=1, adr_src=1, held stable while waiting. When mem_ready: retire=1, then FETCH.
- BRANCH: a=rs1, b=rs2, result_src=00, retire=1, pc_write=take. Then FETCH. Per funct3:
  - 000 SUB, take=zero
  - 001 SUB, take=!zero
  - 100 SLT, take=signed_less_than
  - 101 SLT, take=!signed_less_than
  - 110 SLTU, take=zero
  - 111 SLTU, take=!zero
  - The ALU's SLTU zero output equals unsigned a<b.
  - funct3 010/011 -> illegal handling.
- JALR: a=rs1, b=imm, ADD (target into alu_out). Then JAL.
- JAL: a=oldPC, b=4, ADD, result_src=00, pc_write=1. Then ALU_WB (writes link). rs1 is always read before rd is written.
- Illegal handling: illegal<=1. ILLEGAL_HALT=1 -> HALT (all strobes 0, retire=0, exit only via rst). ILLEGAL_HALT=0 -> FETCH.

Test Plan:
- rst, then instr=0x002081B3 (add), mem_ready=1 -> states FETCH, DECODE, EXEC_R (alu_operation=0000, src_a=10, src_b=00), ALU_WB (reg_write=1, retire=1); back in FETCH on cycle 5.
- instr=0x402081B3 (sub) -> EXEC_R alu_operation=0001; ALU_WB result_src=00.
- instr=0x00208463 (beq): zero=1 -> BRANCH alu_operation=0001, pc_write=1; zero=0 -> pc_write=0. instr=0x0020E463 (bltu), zero=1 -> alu_operation=1001, pc_write=1.
- instr=0x0000A283 (lw), mem_ready=0 for 3 cycles in MEM_READ -> mem_req=1, adr_src=1 held 4 cycles; then MEM_WB result_src=01, reg_write=1, retire=1.
- instr=0xFFFFFFFF, ILLEGAL_HALT=1 -> illegal=1, HALT with all strobes 0 for 10 cycles; rst -> FETCH, illegal=0.
- sw with mem_ready=0, rst asserted mid-MEM_WRITE -> next cycle FETCH, mem_write=0, no retire.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM.
// Walks each instruction through fetch, decode, execute, memory and writeback
// states, steering the ALU operand muxes and operation code, sequencing the
// memory request/ready handshake and resolving branches from the ALU flags.
// Strobes are decoded combinationally from the current state and instruction;
// only the state and the sticky illegal flag are registered.
module multicycle_control #(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        signed_less_than,
   input  logic        mem_ready,
   output logic [3:0]  alu_operation,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic        adr_src,
   output logic        mem_req,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        retire,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI,
      S_ALU_WB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_HALT
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;
   localparam logic [1:0] A_ZERO  = 2'b11;
   localparam logic [1:0] B_RS2   = 2'b00;
   localparam logic [1:0] B_IMM   = 2'b01;
   localparam logic [1:0] B_FOUR  = 2'b10;
   localparam logic [1:0] R_ALUOUT = 2'b00;
   localparam logic [1:0] R_MEM    = 2'b01;
   localparam logic [1:0] R_ALUC   = 2'b10;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       badBranch;
   logic       unusedInstrBits;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7b5  = instr[30];
   assign badBranch = (funct3 == 3'b010) || (funct3 == 3'b011);
   assign unusedInstrBits = ^{instr[31], instr[29:15], instr[11:7]};
   assign illegal   = illegal_q;

   // ALU operation for register and immediate arithmetic; only R-type may subtract
   function automatic logic [3:0] arithOp(input logic [2:0] f3, input logic isReg,
                                          input logic b30);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = (isReg && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Next-state selection, including the illegal-instruction exit out of decode
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
               OP_REG:            state_d = S_EXEC_R;
               OP_IMM:            state_d = S_EXEC_I;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_EXEC_LUI;
               OP_AUIPC:          state_d = S_ALU_WB;
               OP_BRANCH: begin
                  if (badBranch) begin
                     illegal_d = 1'b1;
                     state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                  end else begin
                     state_d = S_BRANCH;
                  end
               end
               default: begin
                  illegal_d = 1'b1;
                  state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEM_ADR:   state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_EXEC_R,
         S_EXEC_I,
         S_EXEC_LUI:  state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JALR:      state_d = S_JAL;
         S_JAL:       state_d = S_ALU_WB;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_FETCH;
      endcase
   end

   // State and sticky illegal flag; reset always returns to fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Datapath strobes decoded from state; everything is forced quiet while in reset
   always_comb begin
      alu_operation = ALU_ADD;
      alu_src_a     = A_PC;
      alu_src_b     = B_RS2;
      result_src    = R_ALUOUT;
      adr_src       = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req    = 1'b1;
               alu_src_a  = A_PC;
               alu_src_b  = B_FOUR;
               result_src = R_ALUC;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            S_DECODE: begin
               alu_src_a = A_OLDPC;
               alu_src_b = B_IMM;
            end
            S_EXEC_R: begin
               alu_src_a     = A_RS1;
               alu_src_b     = B_RS2;
               alu_operation = arithOp(funct3, 1'b1, funct7b5);
            end
            S_EXEC_I: begin
               alu_src_a     = A_RS1;
               alu_src_b     = B_IMM;
               alu_operation = arithOp(funct3, 1'b0, funct7b5);
            end
            S_EXEC_LUI: begin
               alu_src_a = A_ZERO;
               alu_src_b = B_IMM;
            end
            S_ALU_WB: begin
               result_src = R_ALUOUT;
               reg_write  = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_ADR, S_JALR: begin
               alu_src_a = A_RS1;
               alu_src_b = B_IMM;
            end
            S_MEM_READ: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            S_MEM_WB: begin
               result_src = R_MEM;
               reg_write  = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               adr_src   = 1'b1;
               retire    = mem_ready;
            end
            S_BRANCH: begin
               alu_src_a  = A_RS1;
               alu_src_b  = B_RS2;
               result_src = R_ALUOUT;
               retire     = 1'b1;
               case (funct3)
                  3'b000: begin alu_operation = ALU_SUB;  pc_write = zero;              end
                  3'b001: begin alu_operation = ALU_SUB;  pc_write = !zero;             end
                  3'b100: begin alu_operation = ALU_SLT;  pc_write = signed_less_than;  end
                  3'b101: begin alu_operation = ALU_SLT;  pc_write = !signed_less_than; end
                  3'b110: begin alu_operation = ALU_SLTU; pc_write = zero;              end
                  3'b111: begin alu_operation = ALU_SLTU; pc_write = !zero;             end
                  default: begin alu_operation = ALU_ADD; pc_write = 1'b0;              end
               endcase
            end
            S_JAL: begin
               alu_src_a  = A_OLDPC;
               alu_src_b  = B_FOUR;
               result_src = R_ALUOUT;
               pc_write   = 1'b1;
            end
            default: begin
               alu_operation = ALU_ADD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for the multicycle control FSM.
// The driver applies one input vector per cycle and queues the strobe vector
// it expects; the monitor pops and compares on every falling edge.
module tb_multicycle_control;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        zero;
   logic        signedLessThan;
   logic        memReady;
   logic [3:0]  aluOperation;
   logic [1:0]  aluSrcA;
   logic [1:0]  aluSrcB;
   logic [1:0]  resultSrc;
   logic        adrSrc;
   logic        memReq;
   logic        memWrite;
   logic        irWrite;
   logic        pcWrite;
   logic        regWrite;
   logic        retire;
   logic        illegal;

   typedef struct {
      string       name;
      logic [17:0] vec;
   } expect_t;

   expect_t     sbQueue[$];
   int          checkCount = 0;
   int          failCount  = 0;
   logic [17:0] actualVec;

   // strobe byte layout: {adr_src, mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal}
   localparam logic [7:0] ST_NONE   = 8'b0000_0000;
   localparam logic [7:0] ST_FGO    = 8'b0101_1000;
   localparam logic [7:0] ST_FWAIT  = 8'b0100_0000;
   localparam logic [7:0] ST_WB     = 8'b0000_0110;
   localparam logic [7:0] ST_MEMRD  = 8'b1100_0000;
   localparam logic [7:0] ST_MEMWR  = 8'b1110_0000;
   localparam logic [7:0] ST_TAKE   = 8'b0000_1010;
   localparam logic [7:0] ST_NOTAKE = 8'b0000_0010;
   localparam logic [7:0] ST_JAL    = 8'b0000_1000;
   localparam logic [7:0] ST_ILL    = 8'b0000_0001;

   multicycle_control #(.ILLEGAL_HALT(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .instr            (instr),
      .zero             (zero),
      .signed_less_than (signedLessThan),
      .mem_ready        (memReady),
      .alu_operation    (aluOperation),
      .alu_src_a        (aluSrcA),
      .alu_src_b        (aluSrcB),
      .result_src       (resultSrc),
      .adr_src          (adrSrc),
      .mem_req          (memReq),
      .mem_write        (memWrite),
      .ir_write         (irWrite),
      .pc_write         (pcWrite),
      .reg_write        (regWrite),
      .retire           (retire),
      .illegal          (illegal)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [17:0] mk(input logic [3:0] op, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] rs,
                                      input logic [7:0] st);
      return {op, a, b, rs, st};
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue the expected strobes
   task automatic applyStimulus(input string nm, input logic r, input logic [31:0] ins,
                                input logic z, input logic s, input logic rdy,
                                input logic [17:0] expVec);
      expect_t e;
      @(posedge clk);
      #1;
      rst            = r;
      instr          = ins;
      zero           = z;
      signedLessThan = s;
      memReady       = rdy;
      e.name = nm;
      e.vec  = expVec;
      sbQueue.push_back(e);
   endtask

   task automatic fetchDecode(input string nm, input logic [31:0] ins);
      applyStimulus({nm, "_fetch"},  1'b0, ins, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b10, 2'b10, ST_FGO));
      applyStimulus({nm, "_decode"}, 1'b0, ins, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b01, 2'b01, 2'b00, ST_NONE));
   endtask

   task automatic checkOutput(input string nm, input logic [17:0] expVec, input logic [17:0] act);
      checkCount++;
      if (act !== expVec) begin
         failCount++;
         $display("[TB] FAIL %s: got op=%b a=%b b=%b rs=%b st=%b, wanted op=%b a=%b b=%b rs=%b st=%b",
                  nm, act[17:14], act[13:12], act[11:10], act[9:8], act[7:0],
                  expVec[17:14], expVec[13:12], expVec[11:10], expVec[9:8], expVec[7:0]);
      end
   endtask

   assign actualVec = {aluOperation, aluSrcA, aluSrcB, resultSrc, adrSrc, memReq, memWrite,
                       irWrite, pcWrite, regWrite, retire, illegal};

   // Monitor: compare the oldest queued expectation against the DUT mid-cycle
   always @(negedge clk) begin
      expect_t e;
      if (sbQueue.size() > 0) begin
         e = sbQueue.pop_front();
         checkOutput(e.name, e.vec, actualVec);
      end
   end

   initial begin
      rst = 1'b1; instr = 32'h0; zero = 1'b0; signedLessThan = 1'b0; memReady = 1'b0;

      applyStimulus("reset", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_NONE));

      fetchDecode("add", 32'h002081B3);
      applyStimulus("add_exec", 1'b0, 32'h002081B3, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b10, 2'b00, 2'b00, ST_NONE));
      applyStimulus("add_wb",   1'b0, 32'h002081B3, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_WB));

      fetchDecode("sub", 32'h402081B3);
      applyStimulus("sub_exec", 1'b0, 32'h402081B3, 1'b0, 1'b0, 1'b0, mk(4'b0001, 2'b10, 2'b00, 2'b00, ST_NONE));
      applyStimulus("sub_wb",   1'b0, 32'h402081B3, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_WB));

      fetchDecode("beq_t", 32'h00208463);
      applyStimulus("beq_taken",  1'b0, 32'h00208463, 1'b1, 1'b0, 1'b0, mk(4'b0001, 2'b10, 2'b00, 2'b00, ST_TAKE));
      fetchDecode("beq_n", 32'h00208463);
      applyStimulus("beq_nottaken", 1'b0, 32'h00208463, 1'b0, 1'b0, 1'b0, mk(4'b0001, 2'b10, 2'b00, 2'b00, ST_NOTAKE));
      fetchDecode("bltu", 32'h0020E463);
      applyStimulus("bltu_taken", 1'b0, 32'h0020E463, 1'b1, 1'b0, 1'b0, mk(4'b1001, 2'b10, 2'b00, 2'b00, ST_TAKE));
      fetchDecode("blt", 32'h0020C463);
      applyStimulus("blt_taken",  1'b0, 32'h0020C463, 1'b0, 1'b1, 1'b0, mk(4'b0101, 2'b10, 2'b00, 2'b00, ST_TAKE));
      fetchDecode("bge", 32'h0020D463);
      applyStimulus("bge_nottaken", 1'b0, 32'h0020D463, 1'b0, 1'b1, 1'b0, mk(4'b0101, 2'b10, 2'b00, 2'b00, ST_NOTAKE));

      fetchDecode("srai", 32'h4010D093);
      applyStimulus("srai_exec", 1'b0, 32'h4010D093, 1'b0, 1'b0, 1'b0, mk(4'b0111, 2'b10, 2'b01, 2'b00, ST_NONE));
      applyStimulus("srai_wb",   1'b0, 32'h4010D093, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_WB));

      applyStimulus("lw_fetch_wait", 1'b0, 32'h0000A283, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b10, 2'b10, ST_FWAIT));
      fetchDecode("lw", 32'h0000A283);
      applyStimulus("lw_memadr", 1'b0, 32'h0000A283, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b10, 2'b01, 2'b00, ST_NONE));
      for (int i = 0; i < 3; i++)
         applyStimulus("lw_read_wait", 1'b0, 32'h0000A283, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_MEMRD));
      applyStimulus("lw_read_done", 1'b0, 32'h0000A283, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_MEMRD));
      applyStimulus("lw_wb",        1'b0, 32'h0000A283, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b01, ST_WB));

      fetchDecode("jal", 32'h008000EF);
      applyStimulus("jal_link", 1'b0, 32'h008000EF, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b01, 2'b10, 2'b00, ST_JAL));
      applyStimulus("jal_wb",   1'b0, 32'h008000EF, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_WB));

      fetchDecode("sw", 32'h0020A023);
      applyStimulus("sw_memadr", 1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b10, 2'b01, 2'b00, ST_NONE));
      applyStimulus("sw_wait1",  1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_MEMWR));
      applyStimulus("sw_wait2",  1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_MEMWR));
      applyStimulus("sw_reset",  1'b1, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_NONE));
      applyStimulus("sw_after_reset", 1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b00, 2'b10, 2'b10, ST_FWAIT));
      applyStimulus("sw_refetch", 1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b10, 2'b10, ST_FGO));
      applyStimulus("sw_redecode", 1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b01, 2'b01, 2'b00, ST_NONE));
      applyStimulus("sw_memadr2", 1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b0, mk(4'b0000, 2'b10, 2'b01, 2'b00, ST_NONE));
      applyStimulus("sw_done",   1'b0, 32'h0020A023, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_MEMWR | 8'b0000_0010));

      fetchDecode("ill", 32'hFFFFFFFF);
      for (int i = 0; i < 10; i++)
         applyStimulus("ill_halt", 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_ILL));
      applyStimulus("ill_reset", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b00, 2'b00, ST_ILL));
      applyStimulus("ill_cleared", 1'b0, 32'h002081B3, 1'b0, 1'b0, 1'b1, mk(4'b0000, 2'b00, 2'b10, 2'b10, ST_FGO));

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && sbQueue.size() > 0; i++)
         @(negedge clk);
      #1;
      if (sbQueue.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain: %0d expectations left, wanted 0", sbQueue.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
